// File: rtl/game_sequencer.sv
// Mastermind turn controller: latches the code and guess, then scores with a fixed 20-cycle exact/colour sweep.
// Scoring takes 21 cycles from submit to score_valid. start and submit are ignored while a score is in progress.
module game_sequencer #(
    parameter int MAX_TURNS = 8,
    parameter int CW        = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          submit,
    input  logic [CW-1:0] code0,
    input  logic [CW-1:0] code1,
    input  logic [CW-1:0] code2,
    input  logic [CW-1:0] code3,
    input  logic [CW-1:0] guess0,
    input  logic [CW-1:0] guess1,
    input  logic [CW-1:0] guess2,
    input  logic [CW-1:0] guess3,
    output logic          guess_en,
    output logic          hist_wr,
    output logic          score_valid,
    output logic [2:0]    black,
    output logic [2:0]    white,
    output logic [3:0]    turn,
    output logic          win,
    output logic          lose,
    output logic [2:0]    state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GUESS = 3'd1;
    localparam logic [2:0] S_EXACT = 3'd2;
    localparam logic [2:0] S_COLOR = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_WIN   = 3'd5;
    localparam logic [2:0] S_LOSE  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    black_q, black_d;
    logic [2:0]    white_q, white_d;
    logic [3:0]    turn_q, turn_d;
    logic [3:0]    gmask_q, gmask_d;
    logic [3:0]    cmask_q, cmask_d;
    logic [CW-1:0] code_q  [0:3];
    logic [CW-1:0] code_d  [0:3];
    logic [CW-1:0] guess_q [0:3];
    logic [CW-1:0] guess_d [0:3];

    // EXACT walks i = cnt[1:0]; COLOR walks i = cnt[3:2] (outer), j = cnt[1:0] (inner).
    logic [1:0] idx_i, idx_j;
    assign idx_i = (state_q == S_EXACT) ? cnt_q[1:0] : cnt_q[3:2];
    assign idx_j = cnt_q[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        black_d = black_q;
        white_d = white_q;
        turn_d  = turn_q;
        gmask_d = gmask_q;
        cmask_d = cmask_q;
        code_d  = code_q;
        guess_d = guess_q;
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    code_d[0] = code0;
                    code_d[1] = code1;
                    code_d[2] = code2;
                    code_d[3] = code3;
                    turn_d    = '0;
                    black_d   = '0;
                    white_d   = '0;
                    state_d   = S_GUESS;
                end
            end
            S_GUESS: begin
                if (submit) begin
                    guess_d[0] = guess0;
                    guess_d[1] = guess1;
                    guess_d[2] = guess2;
                    guess_d[3] = guess3;
                    gmask_d    = '0;
                    cmask_d    = '0;
                    black_d    = '0;
                    white_d    = '0;
                    cnt_d      = '0;
                    state_d    = S_EXACT;
                end
            end
            S_EXACT: begin
                if (guess_q[idx_i] == code_q[idx_i]) begin
                    black_d        = black_q + 3'd1;
                    gmask_d[idx_i] = 1'b1;
                    cmask_d[idx_i] = 1'b1;
                end
                if (cnt_q == 4'd3) begin
                    cnt_d   = '0;
                    state_d = S_COLOR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_COLOR: begin
                if (!gmask_q[idx_i] && !cmask_q[idx_j] && (guess_q[idx_i] == code_q[idx_j])) begin
                    white_d        = white_q + 3'd1;
                    gmask_d[idx_i] = 1'b1;
                    cmask_d[idx_j] = 1'b1;
                end
                // Bump turn on entry so the new count is visible alongside score_valid.
                if (cnt_q == 4'd15) begin
                    cnt_d   = '0;
                    turn_d  = turn_q + 4'd1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (black_q == 3'd4) begin
                    state_d = S_WIN;
                end else if (turn_q == 4'(MAX_TURNS)) begin
                    state_d = S_LOSE;
                end else begin
                    state_d = S_GUESS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            black_q <= '0;
            white_q <= '0;
            turn_q  <= '0;
            gmask_q <= '0;
            cmask_q <= '0;
            for (int k = 0; k < 4; k++) begin
                code_q[k]  <= '0;
                guess_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            black_q <= black_d;
            white_q <= white_d;
            turn_q  <= turn_d;
            gmask_q <= gmask_d;
            cmask_q <= cmask_d;
            code_q  <= code_d;
            guess_q <= guess_d;
        end
    end

    assign guess_en    = (state_q == S_GUESS);
    assign hist_wr     = (state_q == S_EXACT) && (cnt_q == 4'd0);
    assign score_valid = (state_q == S_DONE);
    assign win         = (state_q == S_WIN);
    assign lose        = (state_q == S_LOSE);
    assign black       = black_q;
    assign white       = white_q;
    assign turn        = turn_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed Mastermind scenarios plus random games against a colour-count reference model.
module tb_game_sequencer;
    localparam int MAX_TURNS = 8;
    localparam int CW        = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, submit;
    logic [CW-1:0] code0, code1, code2, code3;
    logic [CW-1:0] guess0, guess1, guess2, guess3;
    logic          guess_en, hist_wr, score_valid, win, lose;
    logic [2:0]    black, white, state;
    logic [3:0]    turn;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] m_code;
    int          m_turn;
    int          m_state;

    game_sequencer #(.MAX_TURNS(MAX_TURNS), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .submit(submit),
        .code0(code0), .code1(code1), .code2(code2), .code3(code3),
        .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
        .guess_en(guess_en), .hist_wr(hist_wr), .score_valid(score_valid),
        .black(black), .white(white), .turn(turn), .win(win), .lose(lose),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        logic [11:0] v;
        v = {3'(d), 3'(c), 3'(b), 3'(a)};
        return v;
    endfunction

    // Classic Mastermind scoring: exact hits plus per-colour overlap minus exact hits.
    function automatic void ref_score(input logic [11:0] c, input logic [11:0] g,
                                      output int b, output int w);
        int cc [8];
        int gc [8];
        int tot;
        logic [2:0] cs, gs;
        for (int k = 0; k < 8; k++) begin cc[k] = 0; gc[k] = 0; end
        b = 0;
        for (int p = 0; p < 4; p++) begin
            cs = c[p*3 +: 3];
            gs = g[p*3 +: 3];
            if (cs == gs) b++;
            cc[cs]++;
            gc[gs]++;
        end
        tot = 0;
        for (int k = 0; k < 8; k++) tot += (cc[k] < gc[k]) ? cc[k] : gc[k];
        w = tot - b;
    endfunction

    task automatic set_code(input logic [11:0] v);
        {code3, code2, code1, code0} = v;
    endtask

    task automatic set_guess(input logic [11:0] v);
        {guess3, guess2, guess1, guess0} = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_guess_en"}, guess_en, 0);
        chk({tag, "_hist_wr"}, hist_wr, 0);
        chk({tag, "_score_valid"}, score_valid, 0);
        chk({tag, "_black"}, black, 0);
        chk({tag, "_white"}, white, 0);
        chk({tag, "_turn"}, turn, 0);
        chk({tag, "_win"}, win, 0);
        chk({tag, "_lose"}, lose, 0);
    endtask

    task automatic do_start(input logic [11:0] c);
        set_code(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_code(~c);
        m_code  = c;
        m_turn  = 0;
        m_state = 1;
        chk("start_state", state, 1);
        chk("start_guess_en", guess_en, 1);
        chk("start_turn", turn, 0);
        chk("start_bw", {black, white}, 0);
        chk("start_winlose", {win, lose}, 0);
    endtask

    task automatic do_turn(input logic [11:0] g, input bit poke);
        int eb, ew, sv_at, nsv, xhw;
        logic [2:0] st22;
        logic [2:0] wl_en;
        ref_score(m_code, g, eb, ew);
        set_guess(g);
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        chk("hist_wr_t1", hist_wr, 1);
        chk("exact_state", state, 2);
        sv_at = 0; nsv = 0; xhw = 0; st22 = '0; wl_en = '0;
        for (int k = 2; k <= 24; k++) begin
            if (poke && (k == 5 || k == 10)) begin
                submit = 1'b1;
                start  = 1'b1;
                set_code(12'($urandom));
                set_guess(12'($urandom));
            end
            @(negedge clk);
            submit = 1'b0;
            start  = 1'b0;
            if (hist_wr) xhw++;
            if (score_valid) begin
                nsv++;
                if (sv_at == 0) begin
                    sv_at = k;
                    chk("black", black, eb);
                    chk("white", white, ew);
                    chk("turn_at_sv", turn, m_turn + 1);
                end
            end
            if (k == 22) begin
                st22  = state;
                wl_en = {win, lose, guess_en};
            end
        end
        m_turn++;
        if (eb == 4)                  m_state = 5;
        else if (m_turn == MAX_TURNS) m_state = 6;
        else                          m_state = 1;
        chk("sv_latency", sv_at, 21);
        chk("sv_count", nsv, 1);
        chk("extra_hist_wr", xhw, 0);
        chk("post_state", st22, m_state);
        chk("post_win_lose_en", wl_en, {m_state == 5, m_state == 6, m_state == 1});
        chk("post_bw_hold", {black, white}, {3'(eb), 3'(ew)});
    endtask

    task automatic idle_pulse(input string tag, input bit p_sub, input bit p_start, input int exp_state);
        int nsv, nhw;
        nsv = 0; nhw = 0;
        submit = p_sub;
        start  = p_start;
        @(negedge clk);
        submit = 1'b0;
        start  = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (score_valid) nsv++;
            if (hist_wr) nhw++;
            @(negedge clk);
        end
        chk({tag, "_state"}, state, exp_state);
        chk({tag, "_no_activity"}, nsv + nhw, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; submit = 1'b0;
        set_code('0); set_guess('0);
        m_code = '0; m_turn = 0; m_state = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        idle_pulse("idle_submit", 1'b1, 1'b0, 0);

        do_start(pk(1, 2, 3, 4));
        do_turn(pk(4, 3, 2, 1), 1'b0);
        do_turn(pk(1, 2, 3, 4), 1'b1);
        chk("win_turn", turn, 2);

        do_start(pk(1, 1, 2, 2));
        do_turn(pk(1, 2, 1, 1), 1'b0);
        set_code(pk(7, 7, 7, 7));
        idle_pulse("guess_start", 1'b0, 1'b1, 1);
        chk("guess_start_turn", turn, 1);
        while (m_state == 1) do_turn(pk(0, 0, 0, 0), 1'b0);
        chk("lose_turn", turn, MAX_TURNS);
        chk("lose_level", lose, 1);
        idle_pulse("lose_submit", 1'b1, 1'b0, 6);

        do_start(pk(5, 5, 5, 5));
        do_turn(pk(5, 0, 0, 0), 1'b1);

        set_guess(pk(5, 5, 0, 0));
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        m_state = 0;
        idle_pulse("after_reset", 1'b1, 1'b0, 0);

        for (int gm = 0; gm < 6; gm++) begin
            do_start(12'($urandom));
            while (m_state == 1) begin
                if ($urandom_range(0, 3) == 0) do_turn(m_code, $urandom_range(0, 1) == 1);
                else                           do_turn(12'($urandom), $urandom_range(0, 1) == 1);
            end
            chk("game_end_turn", turn, m_turn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Turn-level controller for the Mastermind datapath.
- Latches the secret code from the PRNG when a game starts, gates guess editing, and accepts a submitted guess.
- Commands the history write, scores the guess with a fixed-latency sequential black/white scorer, and decides win or lose.
- Sits between the guess/history blocks and the feedback/SSD path.

Parameters:
- MAX_TURNS, 8, number of guesses allowed per game (1..15).
- CW, 3, bits per colour symbol.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  debounced one-cycle pulse; begins a new game
- submit  in  1  debounced one-cycle pulse; submits the current guess
- code0..code3  in  CW each  PRNG output
- guess0..guess3  in  CW each  current guess selection
- guess_en  out  1  guess editing allowed
- hist_wr  out  1  one-cycle history write strobe
- score_valid  out  1  one-cycle pulse; black/white just updated
- black  out  3  exact matches of last scored guess (0..4)
- white  out  3  colour-only matches of last scored guess (0..4)
- turn  out  4  completed turns this game
- win  out  1  game won (level)
- lose  out  1  game lost (level)
- state  out  3  encoding: IDLE=0, GUESS=1, EXACT=2, COLOR=3, DONE=4, WIN=5, LOSE=6

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - All outputs 0.
  - Latched code, latched guess, used-masks and counters all cleared.
- IDLE, WIN, LOSE: start=1 ->
  - latch code0..3 into the code register;
  - turn=0, black=0, white=0, win=0, lose=0;
  - next state GUESS.
  - submit is ignored in these states.
- GUESS:
  - guess_en=1; it is 0 in every other state.
  - submit=1 -> latch guess0..3 into the guess register; clear gmask, cmask (4 bits each), black, white; next state EXACT.
  - start is ignored in GUESS.
- EXACT (4 cycles, index i=0..3):
  - hist_wr=1 in the first EXACT cycle only.
  - Each cycle: if g[i]==c[i] then black+=1, gmask[i]=1, cmask[i]=1.
- COLOR (16 cycles, i outer 0..3, j inner 0..3, one (i,j) pair per cycle):
  - If !gmask[i] and !cmask[j] and g[i]==c[j] then white+=1, gmask[i]=1, cmask[j]=1.
  - Skipped pairs still consume a cycle, so latency is fixed.
- DONE (1 cycle):
  - score_valid=1; turn+=1.
  - Next state: WIN if black==4; else LOSE if turn+1==MAX_TURNS; else GUESS.
- WIN / LOSE: win=1 or lose=1 respectively, held until start or reset.
- Latency:
  - submit sampled at edge t -> EXACT occupies cycles t+1..t+4, COLOR t+5..t+20, DONE t+21.
  - score_valid high during cycle t+21.
- Output holding:
  - black/white change only inside EXACT/COLOR.
  - Outside scoring they hold the last final score; the final value is stable from DONE onward.
- Ignored inputs: submit or start during EXACT/COLOR/DONE have no effect and are not queued.
- Code/guess inputs: changes to code*/guess* after latching do not affect the score in progress.
- Reset mid-operation: returns to IDLE immediately; no hist_wr or score_valid is emitted afterwards.
- Counter widths: black/white saturate at 4 by construction; turn never exceeds MAX_TURNS.

Test Plan:
- Exact win: start with code=(1,2,3,4), then submit guess=(1,2,3,4) -> hist_wr at t+1; score_valid at t+21 with black=4, white=0, turn=1; WIN next cycle, win=1.
- All-colour: code=(1,2,3,4), guess=(4,3,2,1) -> black=0, white=4, return to GUESS, guess_en=1.
- Duplicates: code=(1,1,2,2), guess=(1,2,1,1) -> black=1, white=2; separately code=(5,5,5,5), guess=(5,0,0,0) -> black=1, white=0.
- Lose: MAX_TURNS=8, 8 non-winning submits -> turn=8, lose=1 after the 8th DONE; a further submit is ignored; start -> turn=0, lose=0, GUESS.
- Ignored inputs: submit and start pulsed at t+5 and t+10 of a scoring run -> exactly one score_valid at t+21, values unaffected; changing code*/guess* mid-score has no effect.
- Reset mid-score: drop rst at t+8 -> asynchronously state=0 and all outputs 0; after release, no score_valid appears and start is required to play.
